// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: round-robin arbiter for two load/store ports onto one data memory,
// with alignment/range checking, load extension and read-modify-write for narrow stores.
module data_mem_arbiter #(
  parameter int MEM_BYTES = 65536
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic        req0_we,
  input  logic [1:0]  req0_size,
  input  logic        req0_unsigned,
  input  logic [31:0] req0_addr,
  input  logic [63:0] req0_wdata,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic        req1_we,
  input  logic [1:0]  req1_size,
  input  logic        req1_unsigned,
  input  logic [31:0] req1_addr,
  input  logic [63:0] req1_wdata,
  output logic        resp0_valid,
  output logic [63:0] resp0_rdata,
  output logic        resp0_err,
  output logic        resp1_valid,
  output logic [63:0] resp1_rdata,
  output logic        resp1_err,
  output logic        mem_rden,
  output logic        mem_wren,
  output logic [31:0] mem_rdaddress,
  output logic [31:0] mem_wraddress,
  output logic [63:0] mem_wdata,
  input  logic [63:0] mem_rdata
);
  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;
  localparam logic [31:0] MAX_ADDR = 32'(MEM_BYTES - 8);
  state_t state_q, state_d;
  logic last_q, port_q, we_q, uns_q, err_q;
  logic [1:0] size_q;
  logic [31:0] addr_q;
  logic [63:0] wdata_q, word_q;
  logic gnt, acc, a_we, a_uns, a_err, sign;
  logic [1:0] a_size;
  logic [31:0] a_addr;
  logic [63:0] a_wdata, mask, ld_data, rsp_data;
  always_comb begin
    gnt = (req0_valid && req1_valid) ? ~last_q : req1_valid;
    acc = (state_q == IDLE) && (req0_valid || req1_valid);
    a_we = gnt ? req1_we : req0_we;
    a_size = gnt ? req1_size : req0_size;
    a_uns = gnt ? req1_unsigned : req0_unsigned;
    a_addr = gnt ? req1_addr : req0_addr;
    a_wdata = gnt ? req1_wdata : req0_wdata;
    a_err = (|(a_addr & ((32'd1 << a_size) - 32'd1))) || (a_addr > MAX_ADDR);
    mask = size_q == 2'd0 ? 64'hFF : size_q == 2'd1 ? 64'hFFFF :
           size_q == 2'd2 ? 64'hFFFF_FFFF : '1;
    sign = size_q == 2'd0 ? word_q[7] : size_q == 2'd1 ? word_q[15] : word_q[31];
    ld_data = (word_q & mask) | ((!uns_q && sign) ? ~mask : 64'd0);
    rsp_data = (err_q || we_q) ? 64'd0 : ld_data;
    state_d = state_q;
    req0_ready = acc && !gnt && !rst;
    req1_ready = acc && gnt && !rst;
    resp0_valid = 1'b0;
    resp1_valid = 1'b0;
    resp0_rdata = '0;
    resp1_rdata = '0;
    resp0_err = 1'b0;
    resp1_err = 1'b0;
    mem_rden = 1'b0;
    mem_wren = 1'b0;
    mem_rdaddress = '0;
    mem_wraddress = '0;
    mem_wdata = '0;
    unique case (state_q)
      IDLE: if (acc) state_d = a_err ? RESP : (a_we && a_size == 2'd3) ? WR : RD;
      RD: begin
        mem_rden = 1'b1;
        mem_rdaddress = addr_q;
        state_d = we_q ? WR : RESP;
      end
      WR: begin
        mem_wren = 1'b1;
        mem_wraddress = addr_q;
        mem_wdata = (wdata_q & mask) | (word_q & ~mask);
        state_d = RESP;
      end
      RESP: begin
        resp0_valid = !port_q;
        resp1_valid = port_q;
        resp0_rdata = port_q ? 64'd0 : rsp_data;
        resp1_rdata = port_q ? rsp_data : 64'd0;
        resp0_err = !port_q && err_q;
        resp1_err = port_q && err_q;
        state_d = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      last_q <= 1'b1;
      port_q <= 1'b0;
      we_q <= 1'b0;
      uns_q <= 1'b0;
      err_q <= 1'b0;
      size_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      word_q <= '0;
    end else begin
      state_q <= state_d;
      if (acc) begin
        last_q <= gnt;
        port_q <= gnt;
        we_q <= a_we;
        uns_q <= a_uns;
        err_q <= a_err;
        size_q <= a_size;
        addr_q <= a_addr;
        wdata_q <= a_wdata;
      end
      if (state_q == RD) word_q <= mem_rdata;
    end
  end
endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter: directed requests with a response scoreboard and a byte-array memory model.
module tb_data_mem_arbiter;
  localparam int MEM_BYTES = 65536;
  logic clk = 1'b0, rst = 1'b1;
  logic req0_valid = 0, req0_we = 0, req0_unsigned = 0, req1_valid = 0, req1_we = 0, req1_unsigned = 0;
  logic [1:0] req0_size = 0, req1_size = 0;
  logic [31:0] req0_addr = 0, req1_addr = 0;
  logic [63:0] req0_wdata = 0, req1_wdata = 0;
  logic req0_ready, req1_ready, resp0_valid, resp1_valid, resp0_err, resp1_err;
  logic [63:0] resp0_rdata, resp1_rdata, mem_wdata, mem_rdata;
  logic mem_rden, mem_wren;
  logic [31:0] mem_rdaddress, mem_wraddress;
  logic [7:0] mem [0:MEM_BYTES-1];
  typedef struct {int p; logic [63:0] d; logic e; int due;} exp_t;
  exp_t q[$];
  int checks = 0, errors = 0, cyc = 0, wren_cnt = 0, rden_cnt = 0, exp_wren = 0, exp_rden = 0;
  int resp_cnt [2] = '{0, 0};
  logic [63:0] last_wdata = 0;

  data_mem_arbiter #(.MEM_BYTES(MEM_BYTES)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we), .req0_size(req0_size),
    .req0_unsigned(req0_unsigned), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we), .req1_size(req1_size),
    .req1_unsigned(req1_unsigned), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .resp0_valid(resp0_valid), .resp0_rdata(resp0_rdata), .resp0_err(resp0_err),
    .resp1_valid(resp1_valid), .resp1_rdata(resp1_rdata), .resp1_err(resp1_err),
    .mem_rden(mem_rden), .mem_wren(mem_wren), .mem_rdaddress(mem_rdaddress),
    .mem_wraddress(mem_wraddress), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always_comb begin
    mem_rdata = '0;
    for (int i = 0; i < 8; i++) mem_rdata[8*i +: 8] = mem[16'(mem_rdaddress + 32'(i))];
  end
  always @(posedge clk)
    if (mem_wren) for (int i = 0; i < 8; i++) mem[16'(mem_wraddress + 32'(i))] <= mem_wdata[8*i +: 8];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) if (!rst) begin
    if (mem_wren) begin wren_cnt++; last_wdata = mem_wdata; end
    if (mem_rden) rden_cnt++;
    if (!mem_rden && mem_rdaddress !== 0) chk("rdaddr_idle", 64'(mem_rdaddress), 0);
    if (!mem_wren && (mem_wdata | 64'(mem_wraddress)) !== 0) chk("wr_idle", mem_wdata | 64'(mem_wraddress), 0);
    if (resp0_valid || resp1_valid) begin
      chk("resp_both", 64'(resp0_valid && resp1_valid), 0);
      if (q.size() == 0) chk("unexpected_resp", 1, 0);
      else begin
        exp_t e;
        e = q.pop_front();
        resp_cnt[resp1_valid ? 1 : 0]++;
        chk("resp_port", 64'(resp1_valid), 64'(e.p));
        chk("resp_rdata", resp1_valid ? resp1_rdata : resp0_rdata, e.d);
        chk("resp_err", 64'(resp1_valid ? resp1_err : resp0_err), 64'(e.e));
        chk("resp_latency", 64'(cyc), 64'(e.due));
      end
    end
  end

  task automatic drive(input int p, input logic v, input logic we, input logic [1:0] sz, input logic u,
                       input logic [31:0] a, input logic [63:0] wd);
    if (p == 0) begin req0_valid = v; req0_we = we; req0_size = sz; req0_unsigned = u; req0_addr = a; req0_wdata = wd; end
    else begin req1_valid = v; req1_we = we; req1_size = sz; req1_unsigned = u; req1_addr = a; req1_wdata = wd; end
  endtask

  task automatic wait_ready(input int p, output int c);
    int n = 0;
    @(negedge clk);
    while (!(p == 0 ? req0_ready : req1_ready) && n < 20) begin @(negedge clk); n++; end
    chk("ready_timeout", 64'(p == 0 ? req0_ready : req1_ready), 1);
    c = cyc;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 20) begin @(negedge clk); n++; end
    chk("drain", 64'(q.size()), 0);
    q.delete();
    chk("wren_count", 64'(wren_cnt), 64'(exp_wren));
    chk("rden_count", 64'(rden_cnt), 64'(exp_rden));
  endtask

  task automatic req(input int p, input logic we, input logic [1:0] sz, input logic u, input logic [31:0] a,
                     input logic [63:0] wd, input logic [63:0] er, input logic ee, input int lat);
    int c;
    @(posedge clk); #1;
    drive(p, 1, we, sz, u, a, wd);
    wait_ready(p, c);
    q.push_back('{p, er, ee, c + lat});
    if (we && !ee) exp_wren++;
    if (!ee && !(we && sz == 2'd3)) exp_rden++;
    @(posedge clk); #1;
    drive(p, 0, 0, 0, 0, 0, 0);
    drain();
  endtask

  initial begin
    int c, w0;
    req0_valid = 1; req1_valid = 1;
    repeat (2) @(negedge clk);
    chk("reset_outputs", {req0_ready, req1_ready, resp0_valid, resp1_valid, resp0_err, resp1_err, mem_rden, mem_wren}, 0);
    chk("reset_mem_bus", mem_wdata | 64'(mem_rdaddress) | 64'(mem_wraddress), 0);
    req0_valid = 0; req1_valid = 0;
    @(posedge clk); #1 rst = 0;
    req(0, 1, 3, 0, 32'h10, 64'h1122334455667788, 0, 0, 2);
    chk("sd_wdata", last_wdata, 64'h1122334455667788);
    req(0, 0, 3, 0, 32'h10, 0, 64'h1122334455667788, 0, 2);
    req(1, 1, 0, 0, 32'h10, 64'hAB, 0, 0, 3);
    chk("sb_rmw_wdata", last_wdata, 64'h11223344556677AB);
    req(1, 0, 3, 0, 32'h10, 0, 64'h11223344556677AB, 0, 2);
    req(0, 1, 3, 0, 32'h20, 64'h7766554433221180, 0, 0, 2);
    req(0, 0, 0, 0, 32'h20, 0, 64'hFFFFFFFFFFFFFF80, 0, 2);
    req(1, 0, 0, 1, 32'h20, 0, 64'h0000000000000080, 0, 2);
    req(0, 0, 1, 0, 32'h22, 0, 64'h3322, 0, 2);
    req(1, 0, 2, 1, 32'h24, 0, 64'h77665544, 0, 2);
    req(0, 1, 2, 0, 32'h20, 64'hFFFFFFFFDEADBEEF, 0, 0, 3);
    chk("sw_rmw_wdata", last_wdata, 64'h77665544DEADBEEF);
    req(1, 0, 2, 0, 32'h20, 0, 64'hFFFFFFFFDEADBEEF, 0, 2);
    req(0, 0, 2, 0, 32'h6, 0, 0, 1, 1);
    req(1, 0, 3, 0, MEM_BYTES - 4, 0, 0, 1, 1);
    req(0, 1, 3, 0, 32'h13, 64'h55, 0, 1, 1);
    req(1, 1, 3, 0, MEM_BYTES - 8, 64'hCAFEF00D12345678, 0, 0, 2);
    req(0, 0, 3, 0, MEM_BYTES - 8, 0, 64'hCAFEF00D12345678, 0, 2);
    // Round robin: both ports held valid from reset, grants must alternate 0,1,0,1
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1;
    drive(0, 1, 0, 3, 0, 32'h10, 0);
    drive(1, 1, 0, 2, 0, 32'h20, 0);
    rst = 0;
    resp_cnt = '{0, 0};
    for (int k = 0; k < 4; k++) begin
      int n = 0;
      @(negedge clk);
      while (!(req0_ready || req1_ready) && n < 20) begin @(negedge clk); n++; end
      chk("rr_grant", 64'(req1_ready), 64'(k % 2));
      chk("rr_one_ready", 64'(req0_ready ^ req1_ready), 1);
      q.push_back('{req1_ready ? 1 : 0, req1_ready ? 64'hFFFFFFFFDEADBEEF : 64'h11223344556677AB, 0, cyc + 2});
      exp_rden++;
      @(posedge clk); #1;
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    drain();
    chk("rr_resp0_count", 64'(resp_cnt[0]), 2);
    chk("rr_resp1_count", 64'(resp_cnt[1]), 2);
    // Reset lands in the RD cycle of a byte store: nothing may be written or answered
    req(0, 1, 3, 0, 32'h18, 64'h0102030405060708, 0, 0, 2);
    @(posedge clk); #1;
    drive(1, 1, 1, 0, 0, 32'h18, 64'hEE);
    wait_ready(1, c);
    @(posedge clk); #1;
    rst = 1;
    w0 = wren_cnt;
    @(negedge clk);
    chk("rst_outputs", {req0_ready, req1_ready, resp0_valid, resp1_valid, resp0_err, resp1_err, mem_rden, mem_wren}, 0);
    chk("rst_mem_bus", mem_wdata | 64'(mem_rdaddress) | 64'(mem_wraddress), 0);
    @(posedge clk); #1;
    drive(1, 0, 0, 0, 0, 0, 0);
    rst = 0;
    repeat (6) @(negedge clk);
    chk("rst_no_wren", 64'(wren_cnt), 64'(w0));
    chk("rst_no_resp", 64'(q.size()), 0);
    rden_cnt = exp_rden;
    req(1, 0, 3, 0, 32'h18, 0, 64'h0102030405060708, 0, 2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
